// File: rtl/rv32im_muldiv_pkg.sv
// rv32im_muldiv_pkg: shared constants and types for the RV32M multiply/divide
// sequencer.
//   FUNCT7_MULDIV      funct7 value that marks an R-type op as an M-extension op
//   F3_*               funct3 encodings of the eight M ops
//   state_t            sequencer state encoding
//   a_is_signed/b_is_signed  which operands are treated as two's complement
// Optional build macro used by the sequencer: RV32IM_MULDIV_EARLY_OUT_EN.
package rv32im_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [6:0] funct7);
    return funct7 == FUNCT7_MULDIV;
  endfunction

  // MUL is run unsigned: its low word does not depend on operand signedness.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32im_muldiv_seq_if.sv
// rv32im_muldiv_seq_if: dispatcher/downstream handshake bundle of the
// multiply/divide sequencer. Names are from the sequencer's point of view.
//   i_valid/o_ready              op handshake from the EX-stage dispatcher
//   i_funct3, i_rs1_data, i_rs2_data  op and operands
//   i_flush                      pipeline flush
//   o_valid/i_ready              result handshake to the MEM stage
//   o_result                     result word
//   o_busy                       EX stall request
// Modports: master = dispatcher/pipeline side, slave = sequencer.
interface rv32im_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_funct3;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_busy;

  modport master (
    output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/rv32im_muldiv_iter.sv
// rv32im_muldiv_iter: one combinational step of the unsigned datapath.
//   i_is_div  0 = shift-add multiply step, 1 = restoring shift-subtract step
//   i_acc     2*WIDTH working register
//               multiply: {partial product high, multiplier / product low}
//               divide:   {partial remainder, dividend / quotient}
//   i_opnd    multiplicand (multiply) or divisor (divide), magnitude
//   o_acc     working register after this step
module rv32im_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] sub_diff;

  always_comb begin
    add_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
    if (i_acc[0]) begin
      add_sum = add_sum + {1'b0, i_opnd};
    end
    // Remainder shifted left by one with the next dividend bit; needs WIDTH+1
    // bits because the remainder may already have its top bit set.
    rem_shift = i_acc[2*WIDTH-1:WIDTH-1];
    sub_diff  = rem_shift - {1'b0, i_opnd};
    if (i_is_div) begin
      if (sub_diff[WIDTH]) begin
        o_acc = {rem_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = {sub_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      o_acc = {add_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rv32im_muldiv_seq.sv
// rv32im_muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the EX
// stage. Operands are converted to magnitudes at accept, WIDTH unsigned
// iterations run in BUSY, and the recorded sign is applied on the way out.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    rv32im_muldiv_seq_if.slave (op handshake, result handshake, flush,
//          busy/stall)
// Build macro RV32IM_MULDIV_EARLY_OUT_EN: divide by zero, signed overflow and
// multiply by zero go straight from IDLE to DONE. Results are identical either
// way; only latency changes.
//
// state | meaning
// IDLE  | o_ready high, waiting for an op
// BUSY  | one datapath iteration per cycle, counter 0..WIDTH-1
// DONE  | o_valid high, result held until consumed
module rv32im_muldiv_seq
  import rv32im_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic i_clk,
  input logic i_rst,
  rv32im_muldiv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, acc_init;
  logic [WIDTH-1:0]   opnd_q, opnd_init;
  logic [2:0]         funct3_q;
  logic               neg_lo_q, neg_hi_q, neg_lo_init, neg_hi_init;
  logic               hs, early;
  logic               is_div_in, sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign hs = bus.i_valid && (state_q == IDLE) && !bus.i_flush;

  always_comb begin
    is_div_in   = bus.i_funct3[2];
    sign_a      = a_is_signed(bus.i_funct3) & bus.i_rs1_data[WIDTH-1];
    sign_b      = b_is_signed(bus.i_funct3) & bus.i_rs2_data[WIDTH-1];
    a_mag       = sign_a ? -bus.i_rs1_data : bus.i_rs1_data;
    b_mag       = sign_b ? -bus.i_rs2_data : bus.i_rs2_data;
    b_zero      = (bus.i_rs2_data == '0);
    acc_init    = {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
    opnd_init   = is_div_in ? b_mag : a_mag;
    // Divide by zero leaves the all-ones quotient unsigned; the remainder
    // negation still applies so that |A| comes back out as A.
    neg_lo_init = (sign_a ^ sign_b) & ~(is_div_in & b_zero);
    neg_hi_init = is_div_in & sign_a;
    early       = 1'b0;
`ifdef RV32IM_MULDIV_EARLY_OUT_EN
    if (is_div_in) begin
      if (b_zero) begin
        early    = 1'b1;
        acc_init = {a_mag, {WIDTH{1'b1}}};
      end else if (a_is_signed(bus.i_funct3) &&
                   (bus.i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (bus.i_rs2_data == {WIDTH{1'b1}})) begin
        early    = 1'b1;
        acc_init = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
      end
    end else if ((bus.i_rs1_data == '0) || b_zero) begin
      early    = 1'b1;
      acc_init = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = early ? DONE : BUSY;
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) begin
      state_d = IDLE;
    end
  end

  rv32im_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_is_div (funct3_q[2]),
    .i_acc    (acc_q),
    .i_opnd   (opnd_q),
    .o_acc    (acc_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      funct3_q <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (hs) begin
      cnt_q    <= '0;
      acc_q    <= acc_init;
      opnd_q   <= opnd_init;
      funct3_q <= bus.i_funct3;
      neg_lo_q <= neg_lo_init;
      neg_hi_q <= neg_hi_init;
    end else if ((state_q == BUSY) && !bus.i_flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_step;
    end
  end

  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    bus.o_result = '0;
    if (state_q == DONE) begin
      case (funct3_q)
        F3_MUL:                       bus.o_result = prod_fix[WIDTH-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: bus.o_result = prod_fix[2*WIDTH-1:WIDTH];
        F3_DIV, F3_DIVU:              bus.o_result = quo_fix;
        default:                      bus.o_result = rem_fix;
      endcase
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q == BUSY) || (state_q == DONE);

endmodule

// File: tb/tb_rv32im_muldiv_seq.sv
// Directed bench for rv32im_muldiv_seq: a vector table of ops with
// hand-computed results and latencies, plus hand-written sequences for
// back-pressure, flush and mid-operation reset.
module tb_rv32im_muldiv_seq;
  import rv32im_muldiv_pkg::*;

  localparam int W = 32;
  localparam int FULL_LAT = 33;
`ifdef RV32IM_MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int NVEC = 20;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         early;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[NVEC];

  rv32im_muldiv_seq_if #(.WIDTH(W)) bus ();

  rv32im_muldiv_seq #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // {o_ready, o_valid, o_busy} packed for compact handshake checks
  function automatic logic [W-1:0] hs_flags();
    return W'({bus.o_ready, bus.o_valid, bus.o_busy});
  endfunction

  // Presents an op at the negedge; returns #1 after the handshake edge (cycle 1).
  task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy);
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_funct3   = f3;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_ready    = rdy;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while ((bus.o_valid !== 1'b1) && (lat < 40)) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    start_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b1);
    wait_valid(lat);
    check($sformatf("vec%0d result", i), bus.o_result, vecs[i].exp);
    check($sformatf("vec%0d latency", i), W'(lat), W'(vecs[i].early ? EARLY_LAT : FULL_LAT));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d return to idle", i), hs_flags(), W'(3'b100));
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{F3_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{F3_DIV,    32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{F3_REM,    32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFE, 1'b0};
    vecs[6]  = '{F3_DIVU,   32'h00000014, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{F3_REMU,   32'h00000014, 32'h00000000, 32'h00000014, 1'b1};
    vecs[8]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[9]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[10] = '{F3_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0};
    vecs[11] = '{F3_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0};
    vecs[12] = '{F3_DIV,    32'h00000014, 32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0};
    vecs[13] = '{F3_REM,    32'h00000014, 32'hFFFFFFFA, 32'h00000002, 1'b0};
    vecs[14] = '{F3_DIV,    32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[15] = '{F3_REM,    32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFEC, 1'b1};
    vecs[16] = '{F3_MUL,    32'h00000000, 32'h00000005, 32'h00000000, 1'b1};
    vecs[17] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[18] = '{F3_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[19] = '{F3_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 1'b0};

    rst            = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_funct3   = 3'b000;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_flush    = 1'b0;
    bus.i_ready    = 1'b0;
    #1;
    check("reset flags", hs_flags(), W'(3'b100));
    check("reset result", bus.o_result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Back-pressure: result held while i_ready is low; new op presented
    // meanwhile must be ignored.
    start_op(F3_MUL, 32'h00000007, 32'hFFFFFFFD, 1'b0);
    wait_valid(lat);
    check("bp latency", W'(lat), W'(FULL_LAT));
    bus.i_valid    = 1'b1;
    bus.i_funct3   = F3_DIVU;
    bus.i_rs1_data = 32'h1;
    bus.i_rs2_data = 32'h1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d result", k), bus.o_result, 32'hFFFFFFEB);
      check($sformatf("bp hold%0d flags", k), hs_flags(), W'(3'b011));
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release flags", hs_flags(), W'(3'b100));
    run_vec(10);

    // Flush beats a same-cycle handshake.
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_funct3   = F3_MUL;
    bus.i_rs1_data = 32'h3;
    bus.i_rs2_data = 32'h5;
    bus.i_flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("flush vs accept flags", hs_flags(), W'(3'b100));
    @(posedge clk);
    #1;
    check("flush vs accept still idle", hs_flags(), W'(3'b100));

    // Flush in cycle 10 of a DIVU.
    start_op(F3_DIVU, 32'h00000014, 32'h00000003, 1'b1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush busy before", hs_flags(), W'(3'b001));
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush cycle11 flags", hs_flags(), W'(3'b100));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) seen++;
    end
    check("flush no valid", W'(seen), 32'h0);
    run_vec(4);

    // Flush in DONE with i_ready low discards the result.
    start_op(F3_REMU, 32'h00000064, 32'h00000007, 1'b0);
    wait_valid(lat);
    check("done flush valid seen", W'(bus.o_valid), 32'h1);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    check("done flush flags", hs_flags(), W'(3'b100));
    check("done flush result", bus.o_result, 32'h0);

    // Asynchronous reset in the middle of BUSY.
    start_op(F3_MUL, 32'h00000003, 32'h00000005, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset busy", hs_flags(), W'(3'b001));
    rst = 1'b1;
    #1;
    check("mid reset flags", hs_flags(), W'(3'b100));
    check("mid reset result", bus.o_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
